vga_timing_gen: RTL
===================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FRONT 16, H_SYNC 96, H_BACK 48: horizontal porch and sync widths in pixels.
REQ-003 SHALL have parameters V_ACTIVE 480, V_FRONT 10, V_SYNC 2, V_BACK 33: vertical timing in lines.
REQ-004 SHALL have parameters H_POL 0 and V_POL 0, the sync active level (0 = active-low).
REQ-005 SHALL have parameter CLK_DIV, default 2, the CLK cycles per pixel (legal range 1..16).
REQ-006 SHALL have parameter CW, default 10, the sx/sy width; parameter COLOR_W, default 4, bits per colour channel.
REQ-007 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-008 SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-009 SHALL have port RGB_IN, input, 3*COLOR_W bits: external pixel {R,G,B} for the current sx/sy.
REQ-010 SHALL have ports SX and SY, outputs, CW bits each: the current pixel coordinate.
REQ-011 SHALL have port PIX_STB, output, 1 bit: pixel strobe, high for one CLK cycle per pixel.
REQ-012 SHALL have ports HS, VS and DE, outputs, 1 bit each: horizontal sync, vertical sync and display enable, all registered.
REQ-013 SHALL have ports LINE_START and FRAME_START, outputs, 1 bit each: registered one-cycle pulses.
REQ-014 SHALL have ports R, G and B, outputs, COLOR_W bits each: registered colour.

Function
REQ-015 SHALL derive H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK and V_TOTAL = V_ACTIVE+V_FRONT+V_SYNC+V_BACK.
REQ-016 SHALL run a divider counter 0..CLK_DIV-1 that wraps every CLK; PIX_STB = (divider == CLK_DIV-1) and RST low; with CLK_DIV=1, PIX_STB is high every cycle.
REQ-017 SHALL advance SX by 1 on each PIX_STB; at H_TOTAL-1, SX wraps to 0 and SY advances; at SY = V_TOTAL-1 with SX = H_TOTAL-1, both wrap to 0.
REQ-018 SHALL hold SX and SY when PIX_STB is low.
REQ-019 SHALL, on each PIX_STB, register the state of the pre-increment (SX,SY), so all registered outputs lag SX/SY by exactly one pixel.
REQ-020 SHALL compute DE as SX < H_ACTIVE and SY < V_ACTIVE.
REQ-021 SHALL drive HS to H_POL when H_ACTIVE+H_FRONT <= SX < H_ACTIVE+H_FRONT+H_SYNC, and to ~H_POL otherwise.
REQ-022 SHALL drive VS to V_POL over the V_SYNC lines starting at SY = V_ACTIVE+V_FRONT, for whole lines, and to ~V_POL otherwise.
REQ-023 SHALL pulse LINE_START for one CLK cycle when a pixel with SX = 0 is registered.
REQ-024 SHALL pulse FRAME_START for one CLK cycle when a pixel with SX = 0 and SY = 0 is registered; LINE_START pulses in the same cycle.
REQ-025 SHALL register R/G/B from the selected colour source when DE is 1, and as 0 when DE is 0 (blanking forced).
REQ-026 SHALL keep HS, VS, DE, R, G and B unchanged between strobes.

Reset
REQ-027 SHALL, while RST is high, asynchronously force: divider 0, SX 0, SY 0, PIX_STB 0, DE 0, HS ~H_POL, VS ~V_POL, LINE_START 0, FRAME_START 0, R/G/B 0, and test-pattern state 0.
REQ-028 SHALL treat RST asserted mid-frame as a full restart: the first PIX_STB after release registers pixel (0,0) and pulses FRAME_START.

Configuration
REQ-029 SHALL, when VGA_TEST_PATTERN_EN is defined, ignore RGB_IN and source colour from an internal 8-bar pattern: bar index k (0..7) advances every H_ACTIVE/8 active pixels via a counter (no divider); channel R/G/B is all-ones if k[2]/k[1]/k[0], else 0.
REQ-030 SHALL, when VGA_TEST_PATTERN_EN is undefined, source colour from RGB_IN sampled on PIX_STB, with no pattern logic synthesised.

Verification
REQ-031 SHALL cover defaults, with reset released at cycle 0: PIX_STB high on cycles 1,3,5,…; FRAME_START pulses with the first PIX_STB; the next FRAME_START follows exactly 800*525*2 = 840000 CLK cycles later.
REQ-032 SHALL cover defaults: HS low exactly while registered SX = 656..751 (96 pixels); VS low exactly over registered lines 490..491; DE high for 640x480 pixels per frame.
REQ-033 SHALL cover H_POL=1, V_POL=1, CLK_DIV=1: HS/VS are active-high, PIX_STB is constant 1 after reset, and the line period is 800 CLK cycles.
REQ-034 SHALL cover VGA_TEST_PATTERN_EN with COLOR_W=4: registered active pixels SX 0..79 give RGB 000/000/000, SX 80..159 give B=F, SX 560..639 give all F; RGB is 0 during blanking.
REQ-035 SHALL cover RGB_IN = 12'hABC without the macro: R=A, G=B, B=C while DE=1, and 0 otherwise.
REQ-036 SHALL cover RST pulsed at SX=300, SY=200: outputs take reset values immediately, and FRAME_START pulses on the first PIX_STB after release.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// Pixel-stream bundle of the VGA timing generator: coordinates, strobe, syncs and colour.
// The generator drives it through the master modport; a pixel source / display sink uses slave.
interface vga_timing_gen_if #(
  parameter int CW      = 10,
  parameter int COLOR_W = 4
);
  // PIX_STB acts as a free-running valid with no ready: each high cycle presents
  // coordinate SX/SY, and RGB_IN must hold that pixel's colour in the same cycle.
  logic [3*COLOR_W-1:0] RGB_IN;
  logic [CW-1:0]        SX;
  logic [CW-1:0]        SY;
  logic                 PIX_STB;
  logic                 HS;
  logic                 VS;
  logic                 DE;
  logic                 LINE_START;
  logic                 FRAME_START;
  logic [COLOR_W-1:0]   R;
  logic [COLOR_W-1:0]   G;
  logic [COLOR_W-1:0]   B;

  modport master (
    input  RGB_IN,
    output SX, SY, PIX_STB, HS, VS, DE, LINE_START, FRAME_START, R, G, B
  );

  modport slave (
    output RGB_IN,
    input  SX, SY, PIX_STB, HS, VS, DE, LINE_START, FRAME_START, R, G, B
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel divider, SX/SY counters, registered syncs/DE/colour.
// Define VGA_TEST_PATTERN_EN to replace RGB_IN with an internal 8-bar colour pattern.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int CLK_DIV  = 2,
  parameter int CW       = 10,
  parameter int COLOR_W  = 4
) (
  input  logic CLK,
  input  logic RST,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG   = CW'(H_ACTIVE + H_FRONT);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CW-1:0] VS_BEG   = CW'(V_ACTIVE + V_FRONT);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic          HS_OFF   = (H_POL == 0);
  localparam logic          VS_OFF   = (V_POL == 0);

  logic [DW-1:0]      div_q, div_d;
  logic [CW-1:0]      sx_q, sx_d;
  logic [CW-1:0]      sy_q, sy_d;
  logic               de_q, de_d;
  logic               hs_q, hs_d;
  logic               vs_q, vs_d;
  logic               line_start_q, line_start_d;
  logic               frame_start_q, frame_start_d;
  logic [COLOR_W-1:0] r_q, r_d;
  logic [COLOR_W-1:0] g_q, g_d;
  logic [COLOR_W-1:0] b_q, b_d;

  logic               pix_stb;
  logic               h_act;
  logic               v_act;
  logic [COLOR_W-1:0] pix_r;
  logic [COLOR_W-1:0] pix_g;
  logic [COLOR_W-1:0] pix_b;

  assign pix_stb = (div_q == DIV_LAST) && !RST;
  assign h_act   = (sx_q < H_ACT);
  assign v_act   = (sy_q < V_ACT);

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  localparam int BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

  logic [BW-1:0] bar_cnt_q, bar_cnt_d;
  logic [2:0]    bar_k_q, bar_k_d;

  // Bar position restarts during horizontal blanking so every line begins on bar 0.
  always_comb begin : bar_next
    bar_cnt_d = bar_cnt_q;
    bar_k_d   = bar_k_q;
    if (pix_stb) begin
      if (!h_act) begin
        bar_cnt_d = '0;
        bar_k_d   = '0;
      end else if (bar_cnt_q == BAR_LAST) begin
        bar_cnt_d = '0;
        bar_k_d   = bar_k_q + 3'd1;
      end else begin
        bar_cnt_d = bar_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bar_cnt_q <= '0;
      bar_k_q   <= '0;
    end else begin
      bar_cnt_q <= bar_cnt_d;
      bar_k_q   <= bar_k_d;
    end
  end

  assign pix_r = {COLOR_W{bar_k_q[2]}};
  assign pix_g = {COLOR_W{bar_k_q[1]}};
  assign pix_b = {COLOR_W{bar_k_q[0]}};
`else
  assign pix_r = vga.RGB_IN[3*COLOR_W-1 -: COLOR_W];
  assign pix_g = vga.RGB_IN[2*COLOR_W-1 -: COLOR_W];
  assign pix_b = vga.RGB_IN[COLOR_W-1:0];
`endif

  // Outputs register the pre-increment coordinate, so they lag SX/SY by one pixel.
  always_comb begin : next_state
    div_d         = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    sx_d          = sx_q;
    sy_d          = sy_q;
    de_d          = de_q;
    hs_d          = hs_q;
    vs_d          = vs_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    r_d           = r_q;
    g_d           = g_q;
    b_d           = b_q;
    if (pix_stb) begin
      if (sx_q == H_LAST) begin
        sx_d = '0;
        sy_d = (sy_q == V_LAST) ? '0 : sy_q + 1'b1;
      end else begin
        sx_d = sx_q + 1'b1;
      end
      de_d          = h_act && v_act;
      hs_d          = (sx_q >= HS_BEG && sx_q < HS_END) ? ~HS_OFF : HS_OFF;
      vs_d          = (sy_q >= VS_BEG && sy_q < VS_END) ? ~VS_OFF : VS_OFF;
      line_start_d  = (sx_q == '0);
      frame_start_d = (sx_q == '0) && (sy_q == '0);
      r_d           = (h_act && v_act) ? pix_r : '0;
      g_d           = (h_act && v_act) ? pix_g : '0;
      b_d           = (h_act && v_act) ? pix_b : '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      div_q         <= '0;
      sx_q          <= '0;
      sy_q          <= '0;
      de_q          <= 1'b0;
      hs_q          <= HS_OFF;
      vs_q          <= VS_OFF;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
    end else begin
      div_q         <= div_d;
      sx_q          <= sx_d;
      sy_q          <= sy_d;
      de_q          <= de_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      r_q           <= r_d;
      g_q           <= g_d;
      b_q           <= b_d;
    end
  end

  assign vga.SX          = sx_q;
  assign vga.SY          = sy_q;
  assign vga.PIX_STB     = pix_stb;
  assign vga.DE          = de_q;
  assign vga.HS          = hs_q;
  assign vga.VS          = vs_q;
  assign vga.LINE_START  = line_start_q;
  assign vga.FRAME_START = frame_start_q;
  assign vga.R           = r_q;
  assign vga.G           = g_q;
  assign vga.B           = b_q;

endmodule
